// File: rtl/sysid_probe_pkg.sv
// Shared types and constants for the system-ID probe master.
//   state_e   : probe FSM states
//   ADDR_*    : word addresses of the sysid slave registers
//   *_CNT_W   : widths of the latency and per-phase timeout counters
package sysid_probe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_LAT_ID,
    ST_RD_TS,
    ST_LAT_TS,
    ST_FIN
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam int unsigned LAT_CNT_W = 2;
  localparam int unsigned TO_CNT_W  = 16;

endpackage

// File: rtl/sysid_phase_timer.sv
// Per-phase cycle counter for one Avalon read (request + latency).
//   i_clock, i_reset  : clock, async active-high reset
//   i_clear           : restart both counters (phase boundary)
//   i_enable          : count a cycle of the current phase
//   i_lat_enable      : count a cycle spent waiting for read data
//   o_lat_last_c      : this is the final latency cycle (data valid now)
//   o_timeout_c       : this is the last cycle the phase may occupy
module sysid_phase_timer
  import sysid_probe_pkg::*;
#(
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_lat_enable,
  output logic o_lat_last_c,
  output logic o_timeout_c
);

  localparam logic [LAT_CNT_W-1:0] LAT_LAST =
    (READ_LATENCY == 0) ? LAT_CNT_W'(0) : LAT_CNT_W'(READ_LATENCY - 1);
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_W-1:0]  r_phase_cnt;
  logic [LAT_CNT_W-1:0] r_lat_cnt;

  // Phase counter saturates so a stuck slave can never wrap it back below the limit.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_phase_cnt <= '0;
      r_lat_cnt   <= '0;
    end else if (i_clear) begin
      r_phase_cnt <= '0;
      r_lat_cnt   <= '0;
    end else begin
      if (i_enable && (r_phase_cnt != '1)) begin
        r_phase_cnt <= r_phase_cnt + TO_CNT_W'(1);
      end
      if (i_lat_enable) begin
        r_lat_cnt <= r_lat_cnt + LAT_CNT_W'(1);
      end
    end
  end

  // Counter holds (cycles already spent in phase); equality with LAST marks the final cycle.
  assign o_lat_last_c = (r_lat_cnt == LAT_LAST);
  assign o_timeout_c  = (r_phase_cnt >= TO_LAST);

endmodule

// File: rtl/sysid_probe_master.sv
// Avalon-MM master that reads the sysid ID (addr 0) and build timestamp
// (addr 1) and compares them with build-time expected values.
//   clock, reset        : clock, async active-high reset
//   start               : request a probe (ignored while busy)
//   avm_address/read    : Avalon read request, held while waitrequest
//   avm_waitrequest     : slave stall
//   avm_readdata        : read data, valid READ_LATENCY cycles after accept
//   busy / done         : probe running / probe finished (level)
//   id_match, ts_match  : comparison results, valid while done
//   timeout             : a phase ran out of cycles, valid while done
//   id_value, ts_value  : captured words
module sysid_probe_master
  import sysid_probe_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1537626416,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam bit LAT_ZERO = (READ_LATENCY == 0);

  state_e      r_state;
  logic        r_auto;
  logic        r_addr;
  logic        r_read;
  logic        r_busy;
  logic        r_done;
  logic        r_id_match;
  logic        r_ts_match;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;

  logic w_accept;
  logic w_in_rd;
  logic w_in_lat;
  logic w_phase_done;
  logic w_to_hit;
  logic w_timer_clear;
  logic w_lat_last_c;
  logic w_timeout_c;

  assign w_accept = r_read && !avm_waitrequest;
  assign w_in_rd  = (r_state == ST_RD_ID)  || (r_state == ST_RD_TS);
  assign w_in_lat = (r_state == ST_LAT_ID) || (r_state == ST_LAT_TS);

  // A phase completes when data is in hand this cycle.
  assign w_phase_done = (w_in_rd && w_accept && LAT_ZERO) || (w_in_lat && w_lat_last_c);
  // Completion wins over timeout in the final allowed cycle; an accept that still
  // needs latency cycles after the limit is already too late.
  assign w_to_hit = (w_in_rd || w_in_lat) && w_timeout_c && !w_phase_done;
  assign w_timer_clear = (r_state == ST_IDLE) || (r_state == ST_FIN) || w_phase_done;

  sysid_phase_timer #(
    .READ_LATENCY   (READ_LATENCY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_clear      (w_timer_clear),
    .i_enable     (w_in_rd || w_in_lat),
    .i_lat_enable (w_in_lat),
    .o_lat_last_c (w_lat_last_c),
    .o_timeout_c  (w_timeout_c)
  );

  // Probe sequencer; every output is a register updated here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_auto     <= AUTO_START;
      r_addr     <= ADDR_ID;
      r_read     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_id_match <= 1'b0;
      r_ts_match <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start || r_auto) begin
            r_auto     <= 1'b0;
            r_state    <= ST_RD_ID;
            r_read     <= 1'b1;
            r_addr     <= ADDR_ID;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_id_match <= 1'b0;
            r_ts_match <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
          end
        end

        ST_RD_ID, ST_RD_TS: begin
          if (w_to_hit) begin
            r_read    <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_FIN;
          end else if (w_accept) begin
            if (!LAT_ZERO) begin
              r_read  <= 1'b0;
              r_state <= (r_state == ST_RD_ID) ? ST_LAT_ID : ST_LAT_TS;
            end else if (r_state == ST_RD_ID) begin
              r_id_value <= avm_readdata;
              r_addr     <= ADDR_TS;
              r_state    <= ST_RD_TS;
            end else begin
              r_ts_value <= avm_readdata;
              r_read     <= 1'b0;
              r_state    <= ST_FIN;
            end
          end
        end

        ST_LAT_ID: begin
          if (w_lat_last_c) begin
            r_id_value <= avm_readdata;
            r_read     <= 1'b1;
            r_addr     <= ADDR_TS;
            r_state    <= ST_RD_TS;
          end else if (w_to_hit) begin
            r_timeout <= 1'b1;
            r_state   <= ST_FIN;
          end
        end

        ST_LAT_TS: begin
          if (w_lat_last_c) begin
            r_ts_value <= avm_readdata;
            r_state    <= ST_FIN;
          end else if (w_to_hit) begin
            r_timeout <= 1'b1;
            r_state   <= ST_FIN;
          end
        end

        ST_FIN: begin
          r_id_match <= !r_timeout && (r_id_value == EXPECTED_ID);
          r_ts_match <= !r_timeout && (r_ts_value == EXPECTED_TIMESTAMP);
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end

        default: begin
          r_read  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign avm_address = r_addr;
  assign avm_read    = r_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign id_match    = r_id_match;
  assign ts_match    = r_ts_match;
  assign timeout     = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_sysid_probe_master.sv
// Bench for sysid_probe_master: two instances (defaults / latency 2 + timeout 8),
// each behind a small Avalon slave model with programmable stalls.
module tb_sysid_probe_master;

  localparam logic [31:0] EID0 = 32'd0;
  localparam logic [31:0] ETS0 = 32'd1537626416;
  localparam logic [31:0] EID1 = 32'h1234_5678;
  localparam logic [31:0] ETS1 = 32'hCAFE_F00D;
  localparam int          TO0  = 255;
  localparam int          L1   = 2;
  localparam int          TO1  = 8;

  // {cycles[15:0], timeout, id_match, ts_match, avm_read, id_value, ts_value}
  typedef logic [83:0] res_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  logic        addr0, read0, wait0, busy0, done0, idm0, tsm0, to0;
  logic [31:0] rdata0, idv0, tsv0;
  logic        addr1, read1, wait1, busy1, done1, idm1, tsm1, to1;
  logic [31:0] rdata1, idv1, tsv1;

  sysid_probe_master dut0 (
    .clock(clock), .reset(reset), .start(start0),
    .avm_address(addr0), .avm_read(read0), .avm_waitrequest(wait0), .avm_readdata(rdata0),
    .busy(busy0), .done(done0), .id_match(idm0), .ts_match(tsm0), .timeout(to0),
    .id_value(idv0), .ts_value(tsv0)
  );

  sysid_probe_master #(
    .EXPECTED_ID(EID1), .EXPECTED_TIMESTAMP(ETS1),
    .READ_LATENCY(L1), .TIMEOUT_CYCLES(TO1), .AUTO_START(1'b0)
  ) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .avm_address(addr1), .avm_read(read1), .avm_waitrequest(wait1), .avm_readdata(rdata1),
    .busy(busy1), .done(done1), .id_match(idm1), .ts_match(tsm1), .timeout(to1),
    .id_value(idv1), .ts_value(tsv1)
  );

  // Slave models: stall N cycles per read at each address, then accept.
  logic [31:0] mem0 [2];
  logic [31:0] mem1 [2];
  int          stall0 [2];
  int          stall1 [2];
  int          wcnt0 = 0;
  int          wcnt1 = 0;
  logic        p1v = 1'b0, p2v = 1'b0, p1a = 1'b0, p2a = 1'b0;
  logic [31:0] garb1 = 32'h0BAD_0BAD;

  assign wait0  = read0 && (wcnt0 < stall0[addr0]);
  assign rdata0 = (read0 && !wait0) ? mem0[addr0] : 32'hDEAD_BEEF;
  assign wait1  = read1 && (wcnt1 < stall1[addr1]);
  assign rdata1 = p2v ? mem1[p2a] : garb1;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt0 <= 0;
      wcnt1 <= 0;
    end else begin
      wcnt0 <= (read0 && wait0) ? wcnt0 + 1 : 0;
      wcnt1 <= (read1 && wait1) ? wcnt1 + 1 : 0;
    end
  end

  // Latency-2 slave: data valid only two cycles after acceptance, garbage otherwise.
  always @(posedge clock) begin
    p1v   <= read1 && !wait1;
    p1a   <= addr1;
    p2v   <= p1v;
    p2a   <= p1a;
    garb1 <= $urandom();
  end

  logic        sel = 1'b0;
  logic        b_read, b_wait, b_addr, b_busy, b_done, b_idm, b_tsm, b_to;
  logic [31:0] b_idv, b_tsv;
  assign b_read = sel ? read1 : read0;
  assign b_wait = sel ? wait1 : wait0;
  assign b_addr = sel ? addr1 : addr0;
  assign b_busy = sel ? busy1 : busy0;
  assign b_done = sel ? done1 : done0;
  assign b_idm  = sel ? idm1  : idm0;
  assign b_tsm  = sel ? tsm1  : tsm0;
  assign b_to   = sel ? to1   : to0;
  assign b_idv  = sel ? idv1  : idv0;
  assign b_tsv  = sel ? tsv1  : tsv0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: each phase needs 1 + stalls + latency cycles; a phase needing more
  // than the limit ends after exactly the limit, then one FIN cycle precedes done.
  function automatic res_t model(input int lat, input int tmo, input int s0, input int s1,
                                 input logic [31:0] m0, input logic [31:0] m1,
                                 input logic [31:0] eid, input logic [31:0] ets);
    int n0 = 1 + s0 + lat;
    int n1 = 1 + s1 + lat;
    int cyc;
    logic t;
    logic [31:0] iv = '0;
    logic [31:0] tv = '0;
    if (n0 > tmo) begin
      t = 1'b1;
      cyc = tmo + 1;
    end else begin
      iv = m0;
      if (n1 > tmo) begin
        t = 1'b1;
        cyc = n0 + tmo + 1;
      end else begin
        t = 1'b0;
        tv = m1;
        cyc = n0 + n1 + 1;
      end
    end
    return {16'(cyc), t, (!t && (iv == eid)), (!t && (tv == ets)), 1'b0, iv, tv};
  endfunction

  // Runs one probe; cycles are counted from the edge that leaves IDLE
  // (the start edge, or the first edge after reset release for auto-start).
  task automatic do_probe(input logic which, input logic use_start, input int s0, input int s1,
                          input logic [31:0] m0, input logic [31:0] m1,
                          output res_t obs, output int unstable, output int busy_bad);
    int   cyc;
    logic prev_st;
    logic prev_a;
    if (which) begin
      stall1[0] = s0; stall1[1] = s1; mem1[0] = m0; mem1[1] = m1;
    end else begin
      stall0[0] = s0; stall0[1] = s1; mem0[0] = m0; mem0[1] = m1;
    end
    sel = which;
    if (use_start) begin
      @(negedge clock);
      if (which) start1 = 1'b1;
      else       start0 = 1'b1;
    end
    @(posedge clock);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    cyc = 0;
    unstable = 0;
    busy_bad = b_busy ? 0 : 1;
    prev_st = b_read && b_wait;
    prev_a  = b_addr;
    while (!b_done && cyc < 2000) begin
      @(posedge clock);
      #1;
      cyc++;
      if (!b_done) begin
        if (!b_busy) busy_bad++;
        if (prev_st && (!b_read || b_addr !== prev_a)) unstable++;
      end
      prev_st = b_read && b_wait;
      prev_a  = b_addr;
    end
    if (b_busy) busy_bad++;
    obs = {16'(cyc), b_to, b_idm, b_tsm, b_read, b_idv, b_tsv};
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({addr0, read0, busy0, done0, idm0, tsm0, to0, idv0, tsv0} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut0 got outputs=%h required 0",
               {addr0, read0, busy0, done0, idm0, tsm0, to0, idv0, tsv0});
    end
    n_checks++;
    if ({addr1, read1, busy1, done1, idm1, tsm1, to1, idv1, tsv1} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut1 got outputs=%h required 0",
               {addr1, read1, busy1, done1, idm1, tsm1, to1, idv1, tsv1});
    end
  endtask

  task automatic test_autostart;
    res_t obs, exp;
    int   uns, bb;
    stall1[0] = 0; stall1[1] = 0;
    @(negedge clock);
    reset = 1'b0;
    do_probe(1'b0, 1'b0, 0, 0, EID0, ETS0, obs, uns, bb);
    exp = model(0, TO0, 0, 0, EID0, ETS0, EID0, ETS0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL autostart got %h required %h", obs, exp);
    end
    n_checks++;
    if (bb != 0) begin
      n_fail++;
      $display("FAIL autostart_busy got %0d busy errors required 0", bb);
    end
    n_checks++;
    if (busy1 !== 1'b0 || read1 !== 1'b0) begin
      n_fail++;
      $display("FAIL no_autostart_dut1 got busy=%b read=%b required 0 0", busy1, read1);
    end
  endtask

  task automatic test_wrong_ts;
    res_t obs, exp;
    int   uns, bb;
    do_probe(1'b0, 1'b1, 0, 0, EID0, 32'h5BA0_0000, obs, uns, bb);
    exp = model(0, TO0, 0, 0, EID0, 32'h5BA0_0000, EID0, ETS0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL wrong_ts got %h required %h", obs, exp);
    end
  endtask

  task automatic test_stalls;
    res_t obs, exp;
    int   uns, bb;
    do_probe(1'b0, 1'b1, 4, 4, EID0, ETS0, obs, uns, bb);
    exp = model(0, TO0, 4, 4, EID0, ETS0, EID0, ETS0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL stalls got %h required %h", obs, exp);
    end
    n_checks++;
    if (uns != 0 || bb != 0) begin
      n_fail++;
      $display("FAIL stalls_stable got unstable=%0d busy_err=%0d required 0 0", uns, bb);
    end
  endtask

  task automatic test_random_dut0;
    res_t obs, exp;
    int   uns, bb, s0, s1;
    logic [31:0] m0, m1;
    for (int i = 0; i < 8; i++) begin
      s0 = $urandom_range(0, 5);
      s1 = $urandom_range(0, 5);
      m0 = ($urandom_range(0, 1) != 0) ? EID0 : $urandom();
      m1 = ($urandom_range(0, 1) != 0) ? ETS0 : $urandom();
      do_probe(1'b0, 1'b1, s0, s1, m0, m1, obs, uns, bb);
      exp = model(0, TO0, s0, s1, m0, m1, EID0, ETS0);
      n_checks++;
      if (obs !== exp || uns != 0 || bb != 0) begin
        n_fail++;
        $display("FAIL random_dut0[%0d] got %h unstable=%0d busy_err=%0d required %h 0 0",
                 i, obs, uns, bb, exp);
      end
    end
  endtask

  task automatic test_latency;
    res_t obs, exp;
    int   uns, bb, s0, s1;
    logic [31:0] m0, m1;
    do_probe(1'b1, 1'b1, 0, 0, EID1, ETS1, obs, uns, bb);
    exp = model(L1, TO1, 0, 0, EID1, ETS1, EID1, ETS1);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL latency2 got %h required %h", obs, exp);
    end
    for (int i = 0; i < 5; i++) begin
      s0 = $urandom_range(0, 3);
      s1 = $urandom_range(0, 3);
      m0 = ($urandom_range(0, 1) != 0) ? EID1 : $urandom();
      m1 = ($urandom_range(0, 1) != 0) ? ETS1 : $urandom();
      do_probe(1'b1, 1'b1, s0, s1, m0, m1, obs, uns, bb);
      exp = model(L1, TO1, s0, s1, m0, m1, EID1, ETS1);
      n_checks++;
      if (obs !== exp || uns != 0 || bb != 0) begin
        n_fail++;
        $display("FAIL latency_rand[%0d] got %h unstable=%0d busy_err=%0d required %h 0 0",
                 i, obs, uns, bb, exp);
      end
    end
  endtask

  task automatic test_timeout;
    res_t obs, exp;
    int   uns, bb;
    int   sv0 [4] = '{1000, 0, 5, 6};
    int   sv1 [4] = '{0, 1000, 5, 0};
    for (int i = 0; i < 4; i++) begin
      do_probe(1'b1, 1'b1, sv0[i], sv1[i], EID1, ETS1, obs, uns, bb);
      exp = model(L1, TO1, sv0[i], sv1[i], EID1, ETS1, EID1, ETS1);
      n_checks++;
      if (obs !== exp || bb != 0) begin
        n_fail++;
        $display("FAIL timeout[%0d] got %h busy_err=%0d required %h 0", i, obs, bb, exp);
      end
    end
  endtask

  task automatic test_restart;
    res_t obs, exp;
    int   uns, bb, cyc;
    fork
      do_probe(1'b0, 1'b1, 6, 6, EID0, ETS0, obs, uns, bb);
      begin
        repeat (4) @(negedge clock);
        start0 = 1'b1;
        @(posedge clock);
        #1;
        start0 = 1'b0;
      end
    join
    exp = model(0, TO0, 6, 6, EID0, ETS0, EID0, ETS0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL start_while_busy got %h required %h", obs, exp);
    end
    mem0[1] = 32'h0000_0001;
    stall0[0] = 1;
    stall0[1] = 2;
    @(negedge clock);
    start0 = 1'b1;
    @(posedge clock);
    #1;
    start0 = 1'b0;
    n_checks++;
    if ({done0, idm0, tsm0, to0, idv0, tsv0} !== '0 || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear got flags=%h busy=%b required 0 1",
               {done0, idm0, tsm0, to0, idv0, tsv0}, busy0);
    end
    cyc = 0;
    while (!done0 && cyc < 2000) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    obs = {16'(cyc), to0, idm0, tsm0, read0, idv0, tsv0};
    exp = model(0, TO0, 1, 2, EID0, 32'h0000_0001, EID0, ETS0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL restart_rerun got %h required %h", obs, exp);
    end
  endtask

  task automatic test_reset_mid;
    res_t obs, exp;
    int   uns, bb;
    mem0[0] = EID0;
    mem0[1] = ETS0;
    stall0[0] = 0;
    stall0[1] = 10;
    @(negedge clock);
    start0 = 1'b1;
    @(posedge clock);
    #1;
    start0 = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if (read0 !== 1'b1 || addr0 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rd_ts got read=%b addr=%b required 1 1", read0, addr0);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({addr0, read0, busy0, done0, idm0, tsm0, to0, idv0, tsv0} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got outputs=%h required 0",
               {addr0, read0, busy0, done0, idm0, tsm0, to0, idv0, tsv0});
    end
    @(negedge clock);
    reset = 1'b0;
    do_probe(1'b0, 1'b0, 2, 3, EID0, ETS0, obs, uns, bb);
    exp = model(0, TO0, 2, 3, EID0, ETS0, EID0, ETS0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_autorerun got %h required %h", obs, exp);
    end
  endtask

  initial begin
    mem0[0] = EID0; mem0[1] = ETS0; mem1[0] = EID1; mem1[1] = ETS1;
    stall0[0] = 0; stall0[1] = 0; stall1[0] = 0; stall1[1] = 0;
    test_reset();
    test_autostart();
    test_wrong_ts();
    test_stalls();
    test_random_dut0();
    test_latency();
    test_timeout();
    test_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
